// File: rtl/hazard_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// hazard_ctrl_pkg
// Shared pipeline definitions for the hazard / halt control block.
//   state_e      : hazard controller state encoding (RUN, DRAIN, HALTED)
//   REG_ZERO     : architectural zero register index, never a hazard source
//   DRAIN_CNT_W  : width of the drain sequencing counter
//   is_load_use  : load-use hazard predicate against the registered ID_EX outputs
// -----------------------------------------------------------------------------
package hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_e;

    localparam logic [4:0] REG_ZERO    = 5'd0;
    localparam int         DRAIN_CNT_W = 4;

    // A load in EX blocks the instruction in ID if it writes a register the
    // ID instruction reads. rt only counts when the ID instruction actually
    // sources it (stores/branches/R-type), and r0 is hardwired so never stalls.
    function automatic logic is_load_use(
        input logic       ex_mem_to_reg,
        input logic [4:0] ex_rt,
        input logic [4:0] id_rs,
        input logic [4:0] id_rt,
        input logic       id_uses_rt
    );
        return ex_mem_to_reg && (ex_rt != REG_ZERO) &&
               ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    endfunction

endpackage : hazard_ctrl_pkg

// File: rtl/hazard_ctrl_sat_counter.sv
// -----------------------------------------------------------------------------
// hazard_ctrl_sat_counter
// Event counter that saturates at all-ones instead of wrapping.
//   clock : counting clock (rising edge)
//   reset : asynchronous, active-high clear
//   inc   : count one event this cycle
//   count : events since reset, saturating at 2**CNT_W-1
// -----------------------------------------------------------------------------
module hazard_ctrl_sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples
    // the pre-edge values, independent of the order the simulator runs blocks.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule : hazard_ctrl_sat_counter

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
// Pipeline hazard and halt controller sitting on the control side of ID_EX.
// Stalls on load-use, squashes the wrong-path fetch on taken branches, and
// drains the pipeline on a halt so the debug unit sees it quiescent.
//   clock, reset  : pipeline clock, asynchronous active-high reset
//   idRs, idRt    : source fields of the instruction in ID
//   idUsesRt      : ID instruction reads rt
//   exMemToReg    : a load is in EX (ID_EX memToRegOut)
//   exRt          : load destination register (ID_EX rtOut)
//   branchTaken   : branch/jump resolved taken in ID
//   haltDetect    : halt opcode decoded in ID
//   resume        : debug-unit pulse to leave HALTED
//   pcWrite       : PC load enable
//   ifIdWrite     : IF_ID load enable
//   ifIdClr       : IF_ID synchronous clear
//   idExClr       : ID_EX syncClr, inserts a bubble
//   halted        : pipeline drained and frozen
//   stallCnt      : saturating count of load-use stall cycles
//   flushCnt      : saturating count of branch flush cycles
// -----------------------------------------------------------------------------
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int DRAIN_CYCLES = 4,
    parameter int CNT_W        = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [4:0]       idRs,
    input  logic [4:0]       idRt,
    input  logic             idUsesRt,
    input  logic             exMemToReg,
    input  logic [4:0]       exRt,
    input  logic             branchTaken,
    input  logic             haltDetect,
    input  logic             resume,
    output logic             pcWrite,
    output logic             ifIdWrite,
    output logic             ifIdClr,
    output logic             idExClr,
    output logic             halted,
    output logic [CNT_W-1:0] stallCnt,
    output logic [CNT_W-1:0] flushCnt
);

    localparam logic [DRAIN_CNT_W-1:0] DRAIN_LAST = DRAIN_CNT_W'(DRAIN_CYCLES - 1);

    state_e                  state_q;
    state_e                  state_d;
    logic [DRAIN_CNT_W-1:0]  drain_cnt_q;
    logic [DRAIN_CNT_W-1:0]  drain_cnt_d;

    logic load_use;
    logic pc_write;
    logic if_id_write;
    logic if_id_clr;
    logic id_ex_clr;
    logic stall_inc;
    logic flush_inc;

    assign load_use = is_load_use(exMemToReg, exRt, idRs, idRt, idUsesRt);

    // NOTE: every signal written here gets a default first, so no path through
    // the case/if tree leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        if_id_clr   = 1'b0;
        id_ex_clr   = 1'b1;
        stall_inc   = 1'b0;
        flush_inc   = 1'b0;

        case (state_q)
            RUN: begin
                drain_cnt_d = '0;
                if (load_use) begin
                    // One-cycle bubble; ID is re-presented next cycle, so a
                    // coincident branch or halt is simply seen again then.
                    stall_inc = 1'b1;
                end else if (haltDetect) begin
                    // Halt itself is kept out of EX; start draining.
                    state_d = DRAIN;
                end else if (branchTaken) begin
                    pc_write    = 1'b1;
                    if_id_write = 1'b1;
                    if_id_clr   = 1'b1;
                    id_ex_clr   = 1'b0;
                    flush_inc   = 1'b1;
                end else begin
                    pc_write    = 1'b1;
                    if_id_write = 1'b1;
                    id_ex_clr   = 1'b0;
                end
            end

            DRAIN: begin
                // Frozen front end; bubbles flow until older work retires.
                drain_cnt_d = drain_cnt_q + 1'b1;
                if (drain_cnt_q == DRAIN_LAST) begin
                    state_d     = HALTED;
                    drain_cnt_d = '0;
                end
            end

            HALTED: begin
                if (resume) begin
                    state_d = RUN;
                end
            end

            default: begin
                state_d     = RUN;
                drain_cnt_d = '0;
            end
        endcase

        // During reset the front end is frozen and EX is held empty, whatever
        // the (already reset) state register says.
        if (reset) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            if_id_clr   = 1'b0;
            id_ex_clr   = 1'b1;
            stall_inc   = 1'b0;
            flush_inc   = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= RUN;
            drain_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
        end
    end

    hazard_ctrl_sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (stall_inc),
        .count (stallCnt)
    );

    hazard_ctrl_sat_counter #(
        .CNT_W (CNT_W)
    ) u_flush_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (flush_inc),
        .count (flushCnt)
    );

    assign pcWrite   = pc_write;
    assign ifIdWrite = if_id_write;
    assign ifIdClr   = if_id_clr;
    assign idExClr   = id_ex_clr;
    assign halted    = (state_q == HALTED);

endmodule : hazard_ctrl

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
// Directed self-checking bench for hazard_ctrl (DRAIN_CYCLES=4, CNT_W=4).
// Inputs change 1 time unit after a rising edge; combinational outputs are
// checked in the same cycle, registered ones after the next edge.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

    localparam int CNT_W = 4;

    logic             clock;
    logic             reset;
    logic [4:0]       idRs;
    logic [4:0]       idRt;
    logic             idUsesRt;
    logic             exMemToReg;
    logic [4:0]       exRt;
    logic             branchTaken;
    logic             haltDetect;
    logic             resume;
    logic             pcWrite;
    logic             ifIdWrite;
    logic             ifIdClr;
    logic             idExClr;
    logic             halted;
    logic [CNT_W-1:0] stallCnt;
    logic [CNT_W-1:0] flushCnt;

    int checks   = 0;
    int failures = 0;

    hazard_ctrl #(
        .DRAIN_CYCLES (4),
        .CNT_W        (CNT_W)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .idRs        (idRs),
        .idRt        (idRt),
        .idUsesRt    (idUsesRt),
        .exMemToReg  (exMemToReg),
        .exRt        (exRt),
        .branchTaken (branchTaken),
        .haltDetect  (haltDetect),
        .resume      (resume),
        .pcWrite     (pcWrite),
        .ifIdWrite   (ifIdWrite),
        .ifIdClr     (ifIdClr),
        .idExClr     (idExClr),
        .halted      (halted),
        .stallCnt    (stallCnt),
        .flushCnt    (flushCnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Front-end control outputs as one bundle: {pcWrite, ifIdWrite, ifIdClr, idExClr}.
    task automatic check_ctl(input string tag, input logic [3:0] expected);
        check(tag, {28'd0, pcWrite, ifIdWrite, ifIdClr, idExClr}, {28'd0, expected});
    endtask

    initial begin
        reset       = 1'b1;
        idRs        = 5'd0;
        idRt        = 5'd0;
        idUsesRt    = 1'b0;
        exMemToReg  = 1'b0;
        exRt        = 5'd0;
        branchTaken = 1'b0;
        haltDetect  = 1'b0;
        resume      = 1'b0;

        // Reset state
        #1;
        check_ctl("reset_ctl", 4'b0001);
        check("reset_halted", 32'(halted), 32'd0);
        check("reset_stall",  32'(stallCnt), 32'd0);
        check("reset_flush",  32'(flushCnt), 32'd0);

        step();
        reset = 1'b0;
        #1;
        check_ctl("idle_ctl", 4'b1100);

        // Load-use on rs
        exMemToReg = 1'b1; exRt = 5'd5; idRs = 5'd5;
        #1;
        check_ctl("lu_rs_ctl", 4'b0001);
        step();
        check("lu_rs_stall", 32'(stallCnt), 32'd1);
        exMemToReg = 1'b0;
        #1;
        check_ctl("lu_rs_after", 4'b1100);

        // r0 never hazards
        exMemToReg = 1'b1; exRt = 5'd0; idRs = 5'd0;
        #1;
        check_ctl("lu_r0_ctl", 4'b1100);
        step();
        check("lu_r0_stall", 32'(stallCnt), 32'd1);

        // rt hazard gated by idUsesRt
        exRt = 5'd7; idRt = 5'd7; idRs = 5'd3; idUsesRt = 1'b0;
        #1;
        check_ctl("lu_rt_unused", 4'b1100);
        idUsesRt = 1'b1;
        #1;
        check_ctl("lu_rt_used", 4'b0001);
        step();
        check("lu_rt_stall", 32'(stallCnt), 32'd2);

        // Branch with simultaneous load-use: stall wins
        branchTaken = 1'b1;
        #1;
        check_ctl("br_lu_ctl", 4'b0001);
        step();
        check("br_lu_stall", 32'(stallCnt), 32'd3);
        check("br_lu_flush", 32'(flushCnt), 32'd0);
        exMemToReg = 1'b0;
        #1;
        check_ctl("br_ctl", 4'b1110);
        step();
        check("br_flush", 32'(flushCnt), 32'd1);
        branchTaken = 1'b0; idUsesRt = 1'b0;

        // Halt drain: halt cycle + 4 drain cycles, halted on cycle 6
        haltDetect = 1'b1;
        #1;
        check_ctl("halt_ctl", 4'b0001);
        check("halt_halted", 32'(halted), 32'd0);
        step();
        haltDetect  = 1'b0;
        branchTaken = 1'b1;  // must be ignored while draining
        for (int i = 0; i < 4; i++) begin
            #1;
            check_ctl("drain_ctl", 4'b0001);
            check("drain_halted", 32'(halted), 32'd0);
            step();
        end
        branchTaken = 1'b0;
        check("halted_set", 32'(halted), 32'd1);
        check_ctl("halted_ctl", 4'b0001);
        check("drain_flush", 32'(flushCnt), 32'd1);
        step();
        check("halted_hold", 32'(halted), 32'd1);
        resume = 1'b1;
        #1;
        check_ctl("resume_ctl", 4'b0001);
        step();
        resume = 1'b0;
        #1;
        check("resume_halted", 32'(halted), 32'd0);
        check_ctl("resume_run", 4'b1100);

        // Reset two cycles into DRAIN
        haltDetect = 1'b1;
        step();
        haltDetect = 1'b0;
        step();
        step();
        #2;
        reset = 1'b1;
        #1;
        check("rst_drain_halted", 32'(halted), 32'd0);
        check("rst_drain_stall",  32'(stallCnt), 32'd0);
        check("rst_drain_flush",  32'(flushCnt), 32'd0);
        check_ctl("rst_drain_ctl", 4'b0001);
        step();
        reset = 1'b0;
        #1;
        check_ctl("rst_release_ctl", 4'b1100);
        step();
        check("rst_release_halted", 32'(halted), 32'd0);
        check_ctl("rst_release_run", 4'b1100);

        // Saturation: 20 consecutive load-use cycles with a 4-bit counter
        exMemToReg = 1'b1; exRt = 5'd5; idRs = 5'd5;
        for (int i = 0; i < 20; i++) begin
            step();
            if (i == 14) check("sat_reach", 32'(stallCnt), 32'd15);
        end
        check("sat_hold", 32'(stallCnt), 32'd15);
        check_ctl("sat_ctl", 4'b0001);
        check("sat_flush", 32'(flushCnt), 32'd0);
        exMemToReg = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_hazard_ctrl
